// File: rtl/hog_gradient.sv
// hog_gradient
//   Per-pixel gradient magnitude and unsigned orientation bin for the HOG
//   pipeline. Consumes 3x3 kernels from the line buffer and emits one
//   (magnitude, 9-way bin, border) record per accepted kernel.
//
//   Three register stages with valid/ready backpressure, full throughput:
//     S1: central differences gx, gy (signed), border flag
//     S2: fold into [0,180), |gx|+|gy|, tangent comparisons against Q8 constants
//     S3: bin selection, output registers
//   A kernel accepted on one edge is presented at the outputs after the
//   third edge counting the accept edge.
//
// Ports
//   clk       clock, all state on rising edge
//   rst       asynchronous active-low reset
//   k_valid   kernel valid
//   k_ready   block can accept a kernel (combinational from g_ready)
//   kernel    p[r][c] at bits [(3r+c)*DATA_WIDTH +: DATA_WIDTH],
//             r=0 newest line (bottom), c=0 oldest column (left)
//   k_border  kernel straddles a line/frame border
//   g_valid   result valid
//   g_ready   downstream accepts result
//   g_mag     |gx|+|gy|
//   g_bin     orientation bin 0..8, 20 degrees each over 0..180
//   g_border  k_border carried with the result
//
// Configuration
//   GRAD_BORDER_ZERO_EN  when defined, border results carry g_mag=0, g_bin=0
//                        (g_border still asserted).

module hog_gradient #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_WIDTH = 9*DATA_WIDTH,
  parameter int MAG_WIDTH    = DATA_WIDTH+1,
  parameter int BIN_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    k_valid,
  output logic                    k_ready,
  input  logic [KERNEL_WIDTH-1:0] kernel,
  input  logic                    k_border,
  output logic                    g_valid,
  input  logic                    g_ready,
  output logic [MAG_WIDTH-1:0]    g_mag,
  output logic [BIN_WIDTH-1:0]    g_bin,
  output logic                    g_border
);

  localparam int GW = DATA_WIDTH + 2;   // signed gradient width
  localparam int PW = DATA_WIDTH + 12;  // unsigned product width

  // tan(20/40/60/80 deg) in Q8
  localparam logic [PW-1:0] TAN_Q8 [4] = '{PW'(93), PW'(215), PW'(443), PW'(1452)};

  // ---------------------------------------------------------------- control
  logic v1, v2;
  logic ld1, ld2, ld3;

  assign ld3     = !g_valid || g_ready;
  assign ld2     = !v2 || ld3;
  assign ld1     = !v1 || ld2;
  assign k_ready = ld1;

  // ---------------------------------------------------------------- S1 comb
  logic [DATA_WIDTH-1:0] p10, p12, p01, p21;
  logic signed [GW-1:0]  gx_d, gy_d;

  assign p01 = kernel[1*DATA_WIDTH +: DATA_WIDTH];
  assign p10 = kernel[3*DATA_WIDTH +: DATA_WIDTH];
  assign p12 = kernel[5*DATA_WIDTH +: DATA_WIDTH];
  assign p21 = kernel[7*DATA_WIDTH +: DATA_WIDTH];

  assign gx_d = $signed({2'b00, p12}) - $signed({2'b00, p10});
  assign gy_d = $signed({2'b00, p01}) - $signed({2'b00, p21});

  // Corner and centre pixels do not contribute to the central differences.
  logic unused_pixels;
  assign unused_pixels = ^{kernel[0 +: DATA_WIDTH],
                           kernel[2*DATA_WIDTH +: DATA_WIDTH],
                           kernel[4*DATA_WIDTH +: DATA_WIDTH],
                           kernel[6*DATA_WIDTH +: DATA_WIDTH],
                           kernel[8*DATA_WIDTH +: DATA_WIDTH]};

  // ---------------------------------------------------------------- S1 regs
  logic signed [GW-1:0] gx1, gy1;
  logic                 b1;

  // ---------------------------------------------------------------- S2 comb
  logic signed [GW-1:0]  gx_f, gy_f;
  logic [DATA_WIDTH-1:0] ax, ay;
  logic                  sx_d;
  logic [MAG_WIDTH-1:0]  mag_d;
  logic [PW-1:0]         lhs;
  logic [3:0]            c_d;

  always_comb begin
    // Fold the vector into the upper half-plane so the angle is in [0,180).
    gx_f = gy1[GW-1] ? -gx1 : gx1;
    gy_f = gy1[GW-1] ? -gy1 : gy1;
    sx_d = gx_f[GW-1];
    ax   = sx_d ? DATA_WIDTH'(-gx_f) : DATA_WIDTH'(gx_f);
    ay   = DATA_WIDTH'(gy_f);
    mag_d = MAG_WIDTH'(ax) + MAG_WIDTH'(ay);
    lhs   = PW'(ay) << 8;
    c_d   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      c_d[i] = (lhs >= PW'(ax) * TAN_Q8[i]);
    end
  end

  // ---------------------------------------------------------------- S2 regs
  logic [MAG_WIDTH-1:0] mag2;
  logic                 sx2, zero2, b2;
  logic [3:0]           c2;

  // ---------------------------------------------------------------- S3 comb
  logic [BIN_WIDTH-1:0] k_cnt, bin_o;
  logic [MAG_WIDTH-1:0] mag_o;

  always_comb begin
    k_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      k_cnt = k_cnt + BIN_WIDTH'(c2[i]);
    end
    bin_o = sx2 ? (BIN_WIDTH'(8) - k_cnt) : k_cnt;
    mag_o = mag2;
    if (zero2) begin
      bin_o = '0;
      mag_o = '0;
    end
`ifdef GRAD_BORDER_ZERO_EN
    if (b2) begin
      bin_o = '0;
      mag_o = '0;
    end
`endif
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1       <= 1'b0;
      gx1      <= '0;
      gy1      <= '0;
      b1       <= 1'b0;
      v2       <= 1'b0;
      mag2     <= '0;
      sx2      <= 1'b0;
      zero2    <= 1'b0;
      c2       <= '0;
      b2       <= 1'b0;
      g_valid  <= 1'b0;
      g_mag    <= '0;
      g_bin    <= '0;
      g_border <= 1'b0;
    end else begin
      if (ld1) begin
        v1 <= k_valid;
        if (k_valid) begin
          gx1 <= gx_d;
          gy1 <= gy_d;
          b1  <= k_border;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          mag2  <= mag_d;
          sx2   <= sx_d;
          zero2 <= (ax == '0) && (ay == '0);
          c2    <= c_d;
          b2    <= b1;
        end
      end
      if (ld3) begin
        g_valid <= v2;
        if (v2) begin
          g_mag    <= mag_o;
          g_bin    <= bin_o;
          g_border <= b2;
        end
      end
    end
  end

endmodule

// File: tb/tb_hog_gradient.sv
// Self-checking bench for hog_gradient: directed vectors, randomized streams
// under backpressure, border handling and asynchronous reset mid-stream.
module tb_hog_gradient;

  localparam int DW      = 8;
  localparam int KW      = 9*DW;
  localparam int NSTREAM = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          k_valid;
  logic          k_ready;
  logic [KW-1:0] kernel;
  logic          k_border;
  logic          g_valid;
  logic          g_ready;
  logic [DW:0]   g_mag;
  logic [3:0]    g_bin;
  logic          g_border;

  int checks = 0;
  int errors = 0;

  logic [KW-1:0] kv [NSTREAM];
  bit            kb [NSTREAM];

  hog_gradient #(.DATA_WIDTH(DW), .KERNEL_WIDTH(KW), .MAG_WIDTH(DW+1), .BIN_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .k_valid  (k_valid),
    .k_ready  (k_ready),
    .kernel   (kernel),
    .k_border (k_border),
    .g_valid  (g_valid),
    .g_ready  (g_ready),
    .g_mag    (g_mag),
    .g_bin    (g_bin),
    .g_border (g_border)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: central differences, fold to upper half-plane, count how many
  // of the tangent thresholds the slope reaches, mirror for negative gx.
  function automatic void model(input logic [KW-1:0] k, input bit b,
                                output int mag, output int bin);
    int t [4];
    int gx, gy, ax, ay, cnt;
    t = '{93, 215, 443, 1452};
    gx = int'(k[5*DW +: DW]) - int'(k[3*DW +: DW]);
    gy = int'(k[1*DW +: DW]) - int'(k[7*DW +: DW]);
    if (gy < 0) begin
      gx = -gx;
      gy = -gy;
    end
    ax  = (gx < 0) ? -gx : gx;
    ay  = gy;
    mag = ax + ay;
    cnt = 0;
    foreach (t[i]) if (ay * 256 >= ax * t[i]) cnt++;
    bin = (gx < 0) ? 8 - cnt : cnt;
    if (mag == 0) bin = 0;
`ifdef GRAD_BORDER_ZERO_EN
    if (b) begin
      mag = 0;
      bin = 0;
    end
`endif
  endfunction

  function automatic logic [KW-1:0] mk_kernel(input int p10, input int p12,
                                               input int p01, input int p21);
    logic [KW-1:0] k;
    k[31:0]  = $urandom;
    k[63:32] = $urandom;
    k[71:64] = 8'($urandom);
    k[3*DW +: DW] = DW'(p10);
    k[5*DW +: DW] = DW'(p12);
    k[1*DW +: DW] = DW'(p01);
    k[7*DW +: DW] = DW'(p21);
    return k;
  endfunction

  // Called at posedge+1 with an empty pipeline. Checks latency and the result.
  task automatic send_one(input logic [KW-1:0] kk, input bit bb,
                          input int exp_mag, input int exp_bin, input string tag);
    g_ready  = 1'b1;
    k_valid  = 1'b1;
    kernel   = kk;
    k_border = bb;
    #1;
    chk({tag, "_kready"}, k_ready, 1);
    @(posedge clk); #1;
    k_valid = 1'b0;
    chk({tag, "_lat0"}, g_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat1"}, g_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, g_valid, 1);
    chk({tag, "_mag"}, g_mag, exp_mag);
    chk({tag, "_bin"}, g_bin, exp_bin);
    chk({tag, "_border"}, g_border, bb);
    @(posedge clk); #1;
    chk({tag, "_drained"}, g_valid, 0);
  endtask

  task automatic run_stream(input int mode);
    int qm[$], qb[$], qd[$];
    int idx, cyc, m, b;
    bit prev_stall;
    logic [31:0] pm, pb, pd;
    idx = 0; cyc = 0; prev_stall = 0; pm = 0; pb = 0; pd = 0;
    while ((idx < NSTREAM || qm.size() > 0) && cyc < 400) begin
      g_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      k_valid = (idx < NSTREAM);
      if (idx < NSTREAM) begin
        kernel   = kv[idx];
        k_border = kb[idx];
      end
      #1;
      chk("stream_kready", k_ready, !(qm.size() == 3 && !g_ready));
      if (prev_stall) begin
        chk("stall_valid", g_valid, 1);
        chk("stall_mag", g_mag, pm);
        chk("stall_bin", g_bin, pb);
        chk("stall_border", g_border, pd);
      end
      if (g_valid && g_ready) begin
        if (qm.size() == 0) begin
          chk("stream_spurious", 1, 0);
        end else begin
          chk("stream_mag", g_mag, qm.pop_front());
          chk("stream_bin", g_bin, qb.pop_front());
          chk("stream_border", g_border, qd.pop_front());
        end
      end
      if (k_valid && k_ready) begin
        model(kv[idx], kb[idx], m, b);
        qm.push_back(m);
        qb.push_back(b);
        qd.push_back(int'(kb[idx]));
        idx++;
      end
      prev_stall = g_valid && !g_ready;
      pm = g_mag; pb = g_bin; pd = g_border;
      @(posedge clk); #1;
      cyc++;
    end
    k_valid = 1'b0;
    g_ready = 1'b1;
    chk("stream_complete", (idx == NSTREAM && qm.size() == 0), 1);
  endtask

  initial begin
    int m, b;
    rst = 1'b0; k_valid = 1'b0; g_ready = 1'b0; kernel = '0; k_border = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", g_valid, 0);
    chk("rst_mag", g_mag, 0);
    chk("rst_bin", g_bin, 0);
    chk("rst_border", g_border, 0);
    chk("rst_kready", k_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    send_one(mk_kernel(10, 50, 0, 0),   1'b0, 40, 0, "gx40");
    send_one(mk_kernel(7, 7, 20, 100),  1'b0, 80, 4, "gyneg80");
    send_one(mk_kernel(0, 30, 30, 0),   1'b0, 60, 2, "diag45");
    send_one(mk_kernel(30, 0, 30, 0),   1'b0, 60, 6, "diag135");
    send_one({9{8'd77}},                1'b0, 0, 0,  "flat");
    send_one(mk_kernel(50, 10, 5, 5),   1'b0, 40, 8, "gxneg_gy0");
    send_one(mk_kernel(0, 20, 0, 60),   1'b0, 80, 5, "fold108");
    send_one(mk_kernel(255, 0, 255, 0), 1'b0, 510, 6, "maxmag");
`ifdef GRAD_BORDER_ZERO_EN
    send_one(mk_kernel(10, 50, 0, 0),   1'b1, 0, 0,  "border");
`else
    send_one(mk_kernel(10, 50, 0, 0),   1'b1, 40, 0, "border");
`endif

    // Randomized streams: free-flowing, then with 1,0,0,1 backpressure
    for (int i = 0; i < NSTREAM; i++) begin
      kv[i] = mk_kernel(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      kb[i] = ($urandom_range(0, 3) == 0);
    end
    run_stream(0);
    repeat (3) @(posedge clk);
    #1;
    run_stream(1);
    repeat (3) @(posedge clk);
    #1;

    // Fill all three stages while stalled, then reset asynchronously
    g_ready = 1'b0;
    k_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kernel   = mk_kernel(10, 60, 0, 0);
      k_border = 1'b0;
      @(posedge clk); #1;
    end
    k_valid = 1'b0;
    #1;
    model(kernel, 1'b0, m, b);
    chk("full_kready", k_ready, 0);
    chk("full_valid", g_valid, 1);
    chk("full_mag", g_mag, m);
    rst = 1'b0;
    #1;
    chk("arst_valid", g_valid, 0);
    chk("arst_mag", g_mag, 0);
    chk("arst_bin", g_bin, 0);
    chk("arst_kready", k_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_one(mk_kernel(0, 20, 0, 60), 1'b0, 80, 5, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
